// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory wait freezes,
// with a saturating count of cycles in which the PC is held.
module hazard_ctl #(
  parameter int unsigned LOAD_STALLS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_instruction_out,
  input  logic        ID_EX_mem_read,
  input  logic [4:0]  ID_EX_rt,
  input  logic        EX_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        stall_count_clr,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        ex_mem_hold,
  output logic [1:0]  state,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    StRun       = 2'b00,
    StLoadStall = 2'b01,
    StMemWait   = 2'b10
  } state_e;

  state_e     state_q, state_d, ret_q, ret_d, eff_state;
  logic [1:0] cnt_q, cnt_d;
  logic [4:0] rs, rt;
  logic       hazard, memwait;
  logic       unused_instr;

  assign rs           = IF_ID_instruction_out[25:21];
  assign rt           = IF_ID_instruction_out[20:16];
  assign unused_instr = ^{IF_ID_instruction_out[31:26], IF_ID_instruction_out[15:0]};
  assign hazard  = ID_EX_mem_read && (ID_EX_rt != 5'd0) && ((ID_EX_rt == rs) || (ID_EX_rt == rt));
  assign memwait = mem_req && !mem_ready;
  assign state   = state_q;

  // MEM_WAIT acts on behalf of the state it interrupted.
  assign eff_state = (state_q == StMemWait) ? ret_q : state_q;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    ex_mem_hold  = 1'b0;
    state_d      = StRun;
    ret_d        = ret_q;
    cnt_d        = cnt_q;
    if (memwait) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ex_mem_hold = 1'b1;
      state_d     = StMemWait;
      ret_d       = eff_state;
    end else if (eff_state == StLoadStall) begin
      // EX already holds a bubble here, so branch and hazard inputs are ignored.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      cnt_d        = cnt_q - 2'd1;
      state_d      = (cnt_q == 2'd1) ? StRun : StLoadStall;
    end else if (EX_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (LOAD_STALLS > 1) begin
        state_d = StLoadStall;
        cnt_d   = 2'(LOAD_STALLS - 1);
      end
    end
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      ex_mem_hold  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      ret_q       <= StRun;
      cnt_q       <= 2'd0;
      stall_count <= 16'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      if (stall_count_clr) begin
        stall_count <= 16'd0;
      end else if (!pc_write && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl; one instance per LOAD_STALLS value 1..3 on shared inputs.
module tb_hazard_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        mem_read = 1'b0;
  logic [4:0]  ex_rt = 5'd0;
  logic        branch = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        clr = 1'b0;

  logic        pc_w [1:3];
  logic        ifid_w [1:3];
  logic        idex_w [1:3];
  logic        bub [1:3];
  logic        flush [1:3];
  logic        hold [1:3];
  logic [1:0]  st [1:3];
  logic [15:0] sc [1:3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    hazard_ctl #(.LOAD_STALLS(g)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .IF_ID_instruction_out (instr),
      .ID_EX_mem_read        (mem_read),
      .ID_EX_rt              (ex_rt),
      .EX_branch_taken       (branch),
      .mem_req               (mem_req),
      .mem_ready             (mem_ready),
      .stall_count_clr       (clr),
      .pc_write              (pc_w[g]),
      .if_id_write           (ifid_w[g]),
      .id_ex_write           (idex_w[g]),
      .id_ex_bubble          (bub[g]),
      .if_id_flush           (flush[g]),
      .ex_mem_hold           (hold[g]),
      .state                 (st[g]),
      .stall_count           (sc[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 16'h0000};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr = 32'd0; mem_read = 1'b0; ex_rt = 5'd0; branch = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset outputs
    #2;
    chk("rst_pc_write", 32'(pc_w[1]), 32'd0);
    chk("rst_id_ex_write", 32'(idex_w[1]), 32'd0);
    chk("rst_bubble", 32'(bub[1]), 32'd1);
    chk("rst_flush", 32'(flush[1]), 32'd1);
    chk("rst_hold", 32'(hold[1]), 32'd0);
    chk("rst_state", 32'(st[1]), 32'd0);
    chk("rst_stall_count", 32'(sc[1]), 32'd0);
    cyc();
    do_reset();

    // Single load-use bubble with LOAD_STALLS=1
    mem_read = 1'b1; ex_rt = 5'd5; instr = mk(5'd5, 5'd7);
    #1;
    chk("ls1_pc_write", 32'(pc_w[1]), 32'd0);
    chk("ls1_if_id_write", 32'(ifid_w[1]), 32'd0);
    chk("ls1_bubble", 32'(bub[1]), 32'd1);
    cyc();
    mem_read = 1'b0;
    #1;
    chk("ls1_state_after", 32'(st[1]), 32'd0);
    chk("ls1_enables_after", 32'({pc_w[1], ifid_w[1], idex_w[1], bub[1]}), 32'b1110);
    chk("ls1_stall_count", 32'(sc[1]), 32'd1);

    // Three-cycle stall with LOAD_STALLS=3, hazard via rt field
    do_reset();
    mem_read = 1'b1; ex_rt = 5'd9; instr = mk(5'd3, 5'd9);
    #1;
    chk("ls3_c0", 32'({st[3], pc_w[3]}), 32'b000);
    cyc();
    mem_read = 1'b0;
    #1;
    chk("ls3_c1", 32'({st[3], pc_w[3], bub[3], idex_w[3]}), 32'b01011);
    cyc();
    #1;
    chk("ls3_c2", 32'({st[3], pc_w[3]}), 32'b010);
    cyc();
    #1;
    chk("ls3_done", 32'({st[3], pc_w[3], bub[3]}), 32'b0010);
    chk("ls3_stall_count", 32'(sc[3]), 32'd3);

    // LOAD_STALLS=2 interrupted by a 4-cycle memory wait
    do_reset();
    mem_read = 1'b1; ex_rt = 5'd5; instr = mk(5'd5, 5'd0);
    #1;
    chk("mw_c0_pc", 32'(pc_w[2]), 32'd0);
    cyc();
    mem_read = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    chk("mw_c1", 32'({st[2], pc_w[2], idex_w[2], hold[2], bub[2]}), 32'b010010);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk("mw_wait", 32'({st[2], pc_w[2], idex_w[2], hold[2]}), 32'b10001);
    end
    cyc();
    mem_ready = 1'b1;
    #1;
    chk("mw_release", 32'({st[2], pc_w[2], idex_w[2], hold[2], bub[2]}), 32'b100101);
    cyc();
    mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    chk("mw_done", 32'({st[2], pc_w[2]}), 32'b001);
    chk("mw_stall_count", 32'(sc[2]), 32'd6);

    // Branch beats a simultaneous hazard
    do_reset();
    branch = 1'b1; mem_read = 1'b1; ex_rt = 5'd5; instr = mk(5'd5, 5'd5);
    #1;
    chk("br_outputs", 32'({pc_w[2], ifid_w[2], idex_w[2], flush[2], bub[2], hold[2]}),
        32'b111110);
    cyc();
    idle();
    #1;
    chk("br_state", 32'(st[2]), 32'd0);
    chk("br_stall_count", 32'(sc[2]), 32'd0);

    // Branch is ignored inside LOAD_STALL
    do_reset();
    mem_read = 1'b1; ex_rt = 5'd4; instr = mk(5'd4, 5'd1);
    cyc();
    mem_read = 1'b0; branch = 1'b1;
    #1;
    chk("ls_ignore_branch", 32'({st[3], pc_w[3], flush[3]}), 32'b0100);

    // Register zero never creates a hazard
    do_reset();
    mem_read = 1'b1; ex_rt = 5'd0; instr = mk(5'd0, 5'd0);
    #1;
    chk("r0_no_stall", 32'({pc_w[1], bub[1]}), 32'b10);
    cyc();
    #1;
    chk("r0_count", 32'(sc[1]), 32'd0);

    // Saturation of stall_count, then clear during a stall
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (65534) cyc();
    chk("sat_fffe", 32'(sc[1]), 32'h0000FFFE);
    repeat (3) cyc();
    chk("sat_ffff", 32'(sc[1]), 32'h0000FFFF);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_wins", 32'(sc[1]), 32'd0);
    cyc();
    chk("count_after_clr", 32'(sc[1]), 32'd1);

    // Asynchronous reset in the middle of MEM_WAIT
    #2;
    rst = 1'b1;
    #1;
    chk("arst_outputs", 32'({pc_w[1], ifid_w[1], idex_w[1], bub[1], flush[1], hold[1]}),
        32'b000110);
    chk("arst_state", 32'(st[1]), 32'd0);
    chk("arst_count", 32'(sc[1]), 32'd0);
    mem_req = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_state", 32'({st[1], pc_w[1]}), 32'b001);
    cyc();
    chk("post_rst_count", 32'(sc[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
